// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit add/subtract split into STAGES equal chunks, one chunk
//            per pipeline stage, with the carry registered between stages.
//            Valid/ready handshake on both sides; one operation per cycle.
// Options  : define PIPELINED_ADDER_OVF_EN to add the signed-overflow output
//            'ovf', aligned with sum/out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = WIDTH / STAGES;

   // Registered state of each stage. Operand words travel whole so that the
   // upper chunks are skew-delayed; the result word collects one finished
   // chunk per stage so all chunks of an operation leave together.
   logic             v_q [STAGES];
   logic             c_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];

   // Inputs seen by each stage: ports for stage 0, previous stage otherwise.
   logic             in_v [STAGES];
   logic             in_c [STAGES];
   logic [WIDTH-1:0] in_a [STAGES];
   logic [WIDTH-1:0] in_b [STAGES];
   logic [WIDTH-1:0] in_s [STAGES];

   // Per-stage chunk add result (carry in MSB) and updated result word.
   logic [CW:0]      part  [STAGES];
   logic [WIDTH-1:0] nxt_s [STAGES];

   logic adv;

   // The whole pipe moves only when the output slot is free or being drained.
   assign adv       = !v_q[STAGES-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];

   // Stage input selection and per-chunk addition.
   always_comb begin
      in_v[0] = in_valid;
      in_a[0] = a;
      in_b[0] = sub ? ~b : b;
      in_c[0] = sub ? 1'b1 : cin;
      in_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         in_v[k] = v_q[k-1];
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
         in_c[k] = c_q[k-1];
         in_s[k] = s_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         part[k]  = {1'b0, in_a[k][k*CW +: CW]}
                  + {1'b0, in_b[k][k*CW +: CW]}
                  + {{CW{1'b0}}, in_c[k]};
         nxt_s[k] = in_s[k];
         nxt_s[k][k*CW +: CW] = part[k][CW-1:0];
      end
   end

   // Pipeline registers: cleared by reset, shifted together on advance.
   // Data shifts even with bubbles so idle contents stay deterministic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= in_v[k];
            c_q[k] <= part[k][CW];
            a_q[k] <= in_a[k];
            b_q[k] <= in_b[k];
            s_q[k] <= nxt_s[k];
         end
      end
   end

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;
   logic ovf_nxt;

   // Carry into the MSB is recovered from the MSB operand and sum bits.
   assign ovf_nxt = in_a[STAGES-1][WIDTH-1] ^ in_b[STAGES-1][WIDTH-1]
                  ^ nxt_s[STAGES-1][WIDTH-1] ^ part[STAGES-1][CW];
   assign ovf     = ovf_q;

   // Overflow flag registered alongside the final stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_nxt;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench for pipelined_adder (WIDTH=32, STAGES=4):
//            directed carry/subtract cases, random throughput, backpressure,
//            random handshake traffic and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic             ovf;
`endif

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             o;
      int               acc;
   } exp_t;

   exp_t q[$];
   exp_t nxt;
   int   cyc;
   int   errors;
   int   checks;
   bit   lat_chk;
   logic [WIDTH-1:0] ra [100];
   logic [WIDTH-1:0] rb [100];
   logic [WIDTH-1:0] rc [100];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's meaning.
   function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                  input logic ic, input logic is);
      exp_t   m;
      longint sa, sb, r;
      sa = $signed(ia);
      sb = $signed(ib);
      if (is) begin
         m.s = ia - ib;
         m.c = (ia >= ib);
         r   = sa - sb;
      end else begin
         {m.c, m.s} = {1'b0, ia} + {1'b0, ib} + 33'(ic);
         r   = sa + sb + longint'(ic);
      end
      m.o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      m.acc = 0;
      return m;
   endfunction

   task automatic drive(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ic, input logic is);
      in_valid = 1'b1;
      a = ia; b = ib; cin = ic; sub = is;
      nxt = model(ia, ib, ic, is);
   endtask

   task automatic drive_x(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic ic, input logic is,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      in_valid = 1'b1;
      a = ia; b = ib; cin = ic; sub = is;
      nxt.s = es; nxt.c = ec; nxt.o = eo; nxt.acc = 0;
   endtask

   // One clock: check any result drained this cycle, record any accept,
   // then step past the rising edge.
   task automatic tick();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_result", 64'(out_valid), 64'(0));
         end else begin
            e = q.pop_front();
            chk("sum", 64'(sum), 64'(e.s));
            chk("cout", 64'(cout), 64'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
            chk("ovf", 64'(ovf), 64'(e.o));
`endif
            if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
         end
      end
      if (lat_chk && q.size() > 0 && !out_valid && (cyc - q[0].acc) >= STAGES)
         chk("result_due", 64'(out_valid), 64'(1));
      if (in_valid && in_ready) begin
         nxt.acc = cyc;
         q.push_back(nxt);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0; lat_chk = 1'b0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      nxt = model('0, '0, 1'b0, 1'b0);

      // Reset state
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout", 64'(cout), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed carry and subtract cases, back to back
      lat_chk = 1'b1;
      drive_x(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0); tick();
      drive_x(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0); tick();
      drive_x(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0); tick();
      drive_x(32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0); tick();
`ifdef PIPELINED_ADDER_OVF_EN
      drive_x(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1); tick();
      drive_x(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1); tick();
      drive_x(32'd3, 32'd4, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0); tick();
`endif
      in_valid = 1'b0;
      repeat (STAGES + 2) tick();
      chk("directed_drained", 64'(q.size()), 64'(0));

      // Throughput: 100 back-to-back random adds, seeds 1/2/3 for a/b/cin
      void'($urandom(1));
      for (int i = 0; i < 100; i++) ra[i] = $urandom;
      void'($urandom(2));
      for (int i = 0; i < 100; i++) rb[i] = $urandom;
      void'($urandom(3));
      for (int i = 0; i < 100; i++) rc[i] = $urandom;
      for (int i = 0; i < 100; i++) begin
         drive(ra[i], rb[i], rc[i][0], 1'b0);
         tick();
      end
      in_valid = 1'b0;
      repeat (STAGES + 2) tick();
      chk("throughput_drained", 64'(q.size()), 64'(0));

      // Backpressure: fill the pipe, stall the output for 3 cycles
      lat_chk = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         drive($urandom, $urandom, 1'($urandom), 1'($urandom));
         tick();
      end
      out_ready = 1'b0;
      drive($urandom, $urandom, 1'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_out_valid", 64'(out_valid), 64'(1));
         chk("stall_sum", 64'(sum), 64'(q[0].s));
         chk("stall_cout", 64'(cout), 64'(q[0].c));
         tick();
      end
      chk("stall_queue_depth", 64'(q.size()), 64'(STAGES));
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (STAGES + 4) tick();
      chk("backpressure_drained", 64'(q.size()), 64'(0));

      // Random traffic with random output stalls and mixed add/sub
      for (int i = 0; i < 300; i++) begin
         if (!in_valid || q.size() == 0 || q[$].acc == cyc - 1) begin
            if ($urandom_range(0, 3) != 0)
               drive($urandom, $urandom, 1'($urandom), 1'($urandom));
            else
               in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (STAGES + 4) tick();
      chk("random_drained", 64'(q.size()), 64'(0));

      // Reset mid-stream: three operations in flight are discarded
      for (int i = 0; i < 3; i++) begin
         drive($urandom | 32'h1, $urandom, 1'b1, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_sum", 64'(sum), 64'(0));
      chk("midrst_cout", 64'(cout), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      repeat (STAGES + 6) tick();
      chk("post_reset_idle", 64'(out_valid), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
